// File: rtl/pio_pkg.sv
// pio_pkg
// Shared definitions for the PIO execute/control slice: opcode constants,
// JMP condition and SET destination encodings, and the execute FSM states.
package pio_pkg;

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_SET = 3'b111;

  typedef enum logic [2:0] {
    COND_ALWAYS   = 3'b000,
    COND_X_ZERO   = 3'b001,
    COND_X_NZ_DEC = 3'b010,
    COND_Y_ZERO   = 3'b011,
    COND_Y_NZ_DEC = 3'b100,
    COND_X_NE_Y   = 3'b101,
    COND_PIN      = 3'b110,
    COND_OSR      = 3'b111
  } jmp_cond_t;

  typedef enum logic [2:0] {
    DEST_PINS = 3'b000,
    DEST_X    = 3'b001,
    DEST_Y    = 3'b010
  } set_dest_t;

  typedef enum logic {
    EXEC  = 1'b0,
    DELAY = 1'b1
  } exec_state_t;

endpackage

// File: rtl/pio_jmp_cond.sv
// pio_jmp_cond
// Purely combinational evaluation of a JMP condition against the current
// (pre-decrement) scratch registers and the external flags.
// Ports:
//   cond          in  3  : JMP condition field
//   x, y          in  32 : scratch registers
//   pin           in  1  : sampled pin for the PIN condition
//   osr_not_empty in  1  : output shift register non-empty flag
//   taken         out 1  : condition holds
module pio_jmp_cond
  import pio_pkg::*;
(
  input  logic [2:0]  cond,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        pin,
  input  logic        osr_not_empty,
  output logic        taken
);

  // Condition select; the decrementing variants test for non-zero before
  // the decrement is applied by the caller.
  always_comb begin
    taken = 1'b0;
    case (jmp_cond_t'(cond))
      COND_ALWAYS:   taken = 1'b1;
      COND_X_ZERO:   taken = (x == 32'd0);
      COND_X_NZ_DEC: taken = (x != 32'd0);
      COND_Y_ZERO:   taken = (y == 32'd0);
      COND_Y_NZ_DEC: taken = (y != 32'd0);
      COND_X_NE_Y:   taken = (x != y);
      COND_PIN:      taken = pin;
      COND_OSR:      taken = osr_not_empty;
      default:       taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pio_exec_ctrl.sv
// pio_exec_ctrl
// Execute/control stage of a PIO state machine: decodes the instruction at
// the current pc, evaluates JMP conditions, executes SET, runs delay cycles
// and drives the program counter's jump/jump_en/pc_en. Holds X/Y.
// Optional feature macro: PIO_JMP_PIN_EN (adds jmp_pin; enables JMP PIN).
// Ports:
//   clk, rst           : clock, async active-high reset
//   en                 : state-machine enable, low freezes all state
//   instr[15:0]        : instruction word at the current pc
//   jmp_pin            : pin for JMP PIN (only with PIO_JMP_PIN_EN)
//   osr_not_empty      : OSR non-empty flag
//   jump[4:0], jump_en : jump target and take-jump to program_counter
//   pc_en              : advance the pc this edge
//   x, y [31:0]        : scratch registers
//   set_pins[4:0]      : last SET PINS value, set_pins_stb its 1-cycle strobe
//   busy               : high while in DELAY
module pio_exec_ctrl
  import pio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] instr,
`ifdef PIO_JMP_PIN_EN
  input  logic        jmp_pin,
`endif
  input  logic        osr_not_empty,
  output logic [4:0]  jump,
  output logic        jump_en,
  output logic        pc_en,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [4:0]  set_pins,
  output logic        set_pins_stb,
  output logic        busy
);

  logic [2:0]  op;
  logic [4:0]  dly;
  logic [2:0]  field;
  logic [4:0]  addr;
  logic        pin_sel;
  logic        cond_true;
  logic        taken;
  exec_state_t state;
  logic [4:0]  cnt;
  logic        lat_taken;
  logic [4:0]  lat_addr;
  logic        exec_fire;

  assign op    = instr[15:13];
  assign dly   = instr[12:8];
  assign field = instr[7:5];
  assign addr  = instr[4:0];

`ifdef PIO_JMP_PIN_EN
  assign pin_sel = jmp_pin;
`else
  // Without the pin feature JMP PIN can never be taken.
  assign pin_sel = 1'b0;
`endif

  pio_jmp_cond u_jmp_cond (
    .cond          (field),
    .x             (x),
    .y             (y),
    .pin           (pin_sel),
    .osr_not_empty (osr_not_empty),
    .taken         (cond_true)
  );

  assign taken     = (op == OP_JMP) && cond_true;
  assign exec_fire = en && (state == EXEC);
  assign busy      = (state == DELAY);

  // Zero-latency handoff to the program counter. In DELAY the decision and
  // target come from the values latched in the EXEC cycle, not from instr.
  always_comb begin
    pc_en   = 1'b0;
    jump_en = 1'b0;
    jump    = addr;
    if (state == EXEC) begin
      if (en && (dly == 5'd0)) begin
        pc_en   = 1'b1;
        jump_en = taken;
      end
    end else begin
      jump = lat_addr;
      if (en && (cnt == 5'd1)) begin
        pc_en   = 1'b1;
        jump_en = lat_taken;
      end
    end
  end

  // Execute/delay sequencing; the delay counter and the jump decision are
  // captured together so later changes to x/y or instr cannot alter them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EXEC;
      cnt       <= 5'd0;
      lat_taken <= 1'b0;
      lat_addr  <= 5'd0;
    end else if (en) begin
      case (state)
        EXEC: begin
          if (dly != 5'd0) begin
            state     <= DELAY;
            cnt       <= dly;
            lat_taken <= taken;
            lat_addr  <= addr;
          end
        end
        DELAY: begin
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            state <= EXEC;
          end
        end
        default: state <= EXEC;
      endcase
    end
  end

  // Instruction side effects commit only on the EXEC edge; the X--/Y--
  // decrement happens whether or not the jump is taken and wraps at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x            <= 32'd0;
      y            <= 32'd0;
      set_pins     <= 5'd0;
      set_pins_stb <= 1'b0;
    end else begin
      set_pins_stb <= 1'b0;
      if (exec_fire) begin
        if (op == OP_JMP) begin
          if (field == COND_X_NZ_DEC) x <= x - 32'd1;
          if (field == COND_Y_NZ_DEC) y <= y - 32'd1;
        end else if (op == OP_SET) begin
          case (field)
            DEST_PINS: begin
              set_pins     <= addr;
              set_pins_stb <= 1'b1;
            end
            DEST_X:  x <= {27'd0, addr};
            DEST_Y:  y <= {27'd0, addr};
            default: ;
          endcase
        end
      end
    end
  end

endmodule
